// File: rtl/ifm_rx_frame_arb_pkg.sv
// Shared constants and state encoding for the RX frame arbiter.
// Data words carry the end-of-frame marker in their top bit.
package ifm_rx_frame_arb_pkg;

    localparam int DATA_W  = 73;
    localparam int EOF_BIT = 72;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DROP,
        S_EOF
    } state_t;

    function automatic logic is_eof(input logic [DATA_W-1:0] word);
        return word[EOF_BIT];
    endfunction

endpackage

// File: rtl/ifm_rx_frame_arb_if.sv
// Bundle of per-port ingress FIFO signals and the downstream good-FIFO write port.
// The master modport is the arbiter side; the slave modport is the FIFO environment.
interface ifm_rx_frame_arb_if
    import ifm_rx_frame_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = 2
);

    logic [N_PORTS*DATA_W-1:0] port_data_rdata;
    logic [N_PORTS-1:0]        port_data_rden;
    logic [N_PORTS-1:0]        port_info_rdata;
    logic [N_PORTS-1:0]        port_info_empty;
    logic [N_PORTS-1:0]        port_info_rden;
    logic [DATA_W-1:0]         good_fifo_wdata;
    logic                      good_fifo_wren;
    logic                      good_fifo_afull;
    logic [PTR_W-1:0]          gnt_port;
    logic                      frm_drop;
    logic [PTR_W-1:0]          frm_drop_port;

    modport master (
        input  port_data_rdata, port_info_rdata, port_info_empty, good_fifo_afull,
        output port_data_rden, port_info_rden, good_fifo_wdata, good_fifo_wren,
        output gnt_port, frm_drop, frm_drop_port
    );

    modport slave (
        output port_data_rdata, port_info_rdata, port_info_empty, good_fifo_afull,
        input  port_data_rden, port_info_rden, good_fifo_wdata, good_fifo_wren,
        input  gnt_port, frm_drop, frm_drop_port
    );

endinterface

// File: rtl/ifm_rx_frame_arb_rr_arb.sv
// Combinational round-robin pick: rotate requests so the port after rr_last sits at
// bit 0, take the lowest set bit, then rotate the index back.
module ifm_rx_frame_arb_rr_arb #(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   rr_last,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    logic [PTR_W-1:0]     start;
    logic [2*N_PORTS-1:0] dbl;
    logic [N_PORTS-1:0]   rot;
    logic [PTR_W-1:0]     offset;
    logic [PTR_W:0]       sum;

    always_comb begin
        start  = (rr_last == PTR_W'(N_PORTS - 1)) ? '0 : rr_last + 1'b1;
        dbl    = {req, req} >> start;
        rot    = dbl[N_PORTS-1:0];
        offset = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = PTR_W'(i);
            end
        end
        sum    = {1'b0, start} + {1'b0, offset};
        winner = (sum >= (PTR_W+1)'(N_PORTS)) ? PTR_W'(sum - (PTR_W+1)'(N_PORTS))
                                              : sum[PTR_W-1:0];
        any    = |req;
    end

endmodule

// File: rtl/ifm_rx_frame_arb.sv
// Frame-granular round-robin arbiter: merges N ingress buffers into one good FIFO,
// forwarding good frames and silently draining bad ones.
module ifm_rx_frame_arb
    import ifm_rx_frame_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = 2
) (
    input logic                sys_clk,
    input logic                rx_reset,
    ifm_rx_frame_arb_if.master bus
);

    state_t               state;
    logic [PTR_W-1:0]     rr_last;
    logic [PTR_W-1:0]     gnt_q;
    logic [PTR_W-1:0]     winner;
    logic                 any_req;
    logic [N_PORTS-1:0]   req;
    logic [N_PORTS-1:0]   gnt_onehot;
    logic [DATA_W-1:0]    cur_word;
    logic                 pop;

    logic [DATA_W-1:0]    wdata_q;
    logic                 wren_q;
    logic [N_PORTS-1:0]   info_rden_q;
    logic                 drop_q;
    logic [PTR_W-1:0]     drop_port_q;

    assign req        = ~bus.port_info_empty;
    assign gnt_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << gnt_q;
    assign cur_word   = bus.port_data_rdata[int'(gnt_q)*DATA_W +: DATA_W];

    ifm_rx_frame_arb_rr_arb #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .req     (req),
        .rr_last (rr_last),
        .winner  (winner),
        .any     (any_req)
    );

    // Drained bad frames ignore backpressure since nothing is written downstream.
    always_comb begin
        pop = 1'b0;
        if (state == S_XFER) begin
            pop = !bus.good_fifo_afull;
        end else if (state == S_DROP) begin
            pop = 1'b1;
        end
    end

    assign bus.port_data_rden  = pop ? gnt_onehot : '0;
    assign bus.port_info_rden  = info_rden_q;
    assign bus.good_fifo_wdata = wdata_q;
    assign bus.good_fifo_wren  = wren_q;
    assign bus.gnt_port        = gnt_q;
    assign bus.frm_drop        = drop_q;
    assign bus.frm_drop_port   = drop_port_q;

    always_ff @(posedge sys_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state       <= S_IDLE;
            rr_last     <= PTR_W'(N_PORTS - 1);
            gnt_q       <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            info_rden_q <= '0;
            drop_q      <= 1'b0;
            drop_port_q <= '0;
        end else begin
            wren_q      <= 1'b0;
            info_rden_q <= '0;
            drop_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req && !bus.good_fifo_afull) begin
                        gnt_q   <= winner;
                        rr_last <= winner;
                        state   <= bus.port_info_rdata[winner] ? S_XFER : S_DROP;
                    end
                end
                S_XFER: begin
                    if (!bus.good_fifo_afull) begin
                        wdata_q <= cur_word;
                        wren_q  <= 1'b1;
                        if (is_eof(cur_word)) begin
                            info_rden_q <= gnt_onehot;
                            state       <= S_EOF;
                        end
                    end
                end
                S_DROP: begin
                    if (is_eof(cur_word)) begin
                        info_rden_q <= gnt_onehot;
                        drop_q      <= 1'b1;
                        drop_port_q <= gnt_q;
                        state       <= S_EOF;
                    end
                end
                // Bubble lets the popped info FIFO update its empty flag before re-arbitrating.
                S_EOF: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_rx_frame_arb.sv
// Bench for ifm_rx_frame_arb: queue-based port FIFO model, scoreboard of expected
// good-FIFO words and dropped-frame ports, one task per scenario.
module tb_ifm_rx_frame_arb;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int DW = 73;

    logic sys_clk;
    logic rx_reset;

    ifm_rx_frame_arb_if #(.N_PORTS(NP), .PTR_W(PW)) bus ();

    ifm_rx_frame_arb #(.N_PORTS(NP), .PTR_W(PW)) dut (
        .sys_clk  (sys_clk),
        .rx_reset (rx_reset),
        .bus      (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dq [NP][$];
    bit            iq [NP][$];
    logic [DW-1:0] exp_q [$];
    int            exp_drop_q [$];
    int            gnt_log [$];

    int data_rden_cnt [NP];
    int info_rden_cnt [NP];
    int wren_cnt, eof_cnt, drop_cnt, cyc, first_rden_cyc, last_info_cyc;

    logic [NP*DW-1:0] rdata_v;
    logic [NP-1:0]    empty_v;
    logic [NP-1:0]    info_v;
    logic [DW-1:0]    junk_word;
    bit               junk_bit;

    // Port FIFO model: FWFT data/info queues, flushed by the same reset as the DUT.
    always @(posedge sys_clk) begin
        for (int p = 0; p < NP; p++) begin
            if (rx_reset) begin
                dq[p].delete();
                iq[p].delete();
            end else begin
                if (bus.port_data_rden[p] && dq[p].size() > 0) junk_word = dq[p].pop_front();
                if (bus.port_info_rden[p] && iq[p].size() > 0) junk_bit = iq[p].pop_front();
            end
            rdata_v[p*DW +: DW] = (dq[p].size() > 0) ? dq[p][0] : '0;
            empty_v[p]          = (iq[p].size() == 0);
            info_v[p]           = (iq[p].size() > 0) ? iq[p][0] : 1'b0;
        end
        bus.port_data_rdata <= rdata_v;
        bus.port_info_empty <= empty_v;
        bus.port_info_rdata <= info_v;
    end

    // Output monitor and scoreboard comparison.
    always @(negedge sys_clk) begin
        logic [DW-1:0] exp_word;
        int            exp_port;
        if (!rx_reset) begin
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (bus.port_data_rden[p]) data_rden_cnt[p]++;
                if (bus.port_info_rden[p]) begin
                    info_rden_cnt[p]++;
                    last_info_cyc = cyc;
                end
            end
            if (|bus.port_data_rden && first_rden_cyc < 0) first_rden_cyc = cyc;
            checks++;
            if ($countones(bus.port_data_rden) > 1 || $countones(bus.port_info_rden) > 1) begin
                errors++;
                $display("[TB] FAIL onehot_rden: data_rden=%b info_rden=%b, expected at most one bit each",
                         bus.port_data_rden, bus.port_info_rden);
            end
            if (bus.good_fifo_wren) begin
                wren_cnt++;
                if (bus.good_fifo_wdata[72]) eof_cnt++;
                gnt_log.push_back(int'(bus.gnt_port));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_wren: got word %h, expected no write", bus.good_fifo_wdata);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.good_fifo_wdata !== exp_word) begin
                        errors++;
                        $display("[TB] FAIL wdata: got %h expected %h", bus.good_fifo_wdata, exp_word);
                    end
                end
            end
            if (bus.frm_drop) begin
                drop_cnt++;
                checks++;
                if (exp_drop_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_drop: got port %0d, expected no drop", bus.frm_drop_port);
                end else begin
                    exp_port = exp_drop_q.pop_front();
                    if (int'(bus.frm_drop_port) != exp_port) begin
                        errors++;
                        $display("[TB] FAIL frm_drop_port: got %0d expected %0d", bus.frm_drop_port, exp_port);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk_word(input int port, input int fid, input int idx, input bit eof);
        return {eof, 8'(port), 16'(fid), 16'(idx), 32'hA5A5_0000 ^ 32'(idx * 7 + port)};
    endfunction

    task automatic push_frame(input int port, input int len, input bit good, input int fid);
        logic [DW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = mk_word(port, fid, i, (i == len - 1));
            dq[port].push_back(w);
            if (good) exp_q.push_back(w);
        end
        iq[port].push_back(good);
        if (!good) exp_drop_q.push_back(port);
    endtask

    task automatic clear_counts();
        for (int p = 0; p < NP; p++) begin
            data_rden_cnt[p] = 0;
            info_rden_cnt[p] = 0;
        end
        wren_cnt       = 0;
        eof_cnt        = 0;
        drop_cnt       = 0;
        first_rden_cyc = -1;
        last_info_cyc  = -1;
        gnt_log.delete();
    endtask

    task automatic wait_drain(input string name);
        bit   done;
        int   pending;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge sys_clk);
            #1;
            pending = exp_q.size() + exp_drop_q.size();
            for (int p = 0; p < NP; p++) pending += dq[p].size() + iq[p].size();
            if (pending == 0 && bus.port_data_rden == '0) done = 1'b1;
        end
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got pending work after 300 cycles, expected drained", name);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rx_reset = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rx_reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus.port_data_rden !== '0 || bus.port_info_rden !== '0 || bus.good_fifo_wren !== 1'b0 ||
            bus.good_fifo_wdata !== '0 || bus.gnt_port !== '0 || bus.frm_drop !== 1'b0 ||
            bus.frm_drop_port !== '0) begin
            errors++;
            $display("[TB] FAIL %s: got rden=%b info=%b wren=%b wdata=%h gnt=%0d drop=%b dport=%0d, expected all 0",
                     name, bus.port_data_rden, bus.port_info_rden, bus.good_fifo_wren,
                     bus.good_fifo_wdata, bus.gnt_port, bus.frm_drop, bus.frm_drop_port);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs_zero("reset_outputs");
        @(negedge sys_clk);
        rx_reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_good_frame();
        clear_counts();
        push_frame(0, 3, 1'b1, 1);
        wait_drain("good_frame");
        checks++;
        if (wren_cnt != 3 || eof_cnt != 1) begin
            errors++;
            $display("[TB] FAIL good_frame_words: got wren=%0d eof=%0d expected 3 and 1", wren_cnt, eof_cnt);
        end
        checks++;
        if (info_rden_cnt[0] != 1) begin
            errors++;
            $display("[TB] FAIL good_frame_info_rden: got %0d expected 1", info_rden_cnt[0]);
        end
        checks++;
        if (bus.gnt_port !== 2'd0) begin
            errors++;
            $display("[TB] FAIL good_frame_gnt: got %0d expected 0", bus.gnt_port);
        end
    endtask

    task automatic test_bad_frame();
        clear_counts();
        push_frame(2, 4, 1'b0, 2);
        wait_drain("bad_frame");
        checks++;
        if (data_rden_cnt[2] != 4 || wren_cnt != 0) begin
            errors++;
            $display("[TB] FAIL bad_frame_drain: got rden=%0d wren=%0d expected 4 and 0", data_rden_cnt[2], wren_cnt);
        end
        checks++;
        if (drop_cnt != 1 || info_rden_cnt[2] != 1) begin
            errors++;
            $display("[TB] FAIL bad_frame_drop: got drop=%0d info=%0d expected 1 and 1", drop_cnt, info_rden_cnt[2]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_counts();
        for (int p = 0; p < NP; p++) push_frame(p, 2, 1'b1, 10 + p);
        wait_drain("back_to_back");
        checks++;
        if (gnt_log.size() != 8) begin
            errors++;
            $display("[TB] FAIL b2b_words: got %0d expected 8", gnt_log.size());
        end else begin
            for (int k = 0; k < NP; k++) begin
                checks++;
                if (gnt_log[2*k] != k || gnt_log[2*k+1] != k) begin
                    errors++;
                    $display("[TB] FAIL b2b_order: slot %0d got ports %0d,%0d expected %0d",
                             k, gnt_log[2*k], gnt_log[2*k+1], k);
                end
            end
        end
        checks++;
        if (last_info_cyc - first_rden_cyc != 14) begin
            errors++;
            $display("[TB] FAIL b2b_cycles: got span %0d expected 14", last_info_cyc - first_rden_cyc);
        end
        checks++;
        if (bus.port_data_rden !== '0 || bus.good_fifo_wren !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got rden=%b wren=%b expected 0", bus.port_data_rden, bus.good_fifo_wren);
        end
    endtask

    task automatic test_afull_stall();
        bit reached;
        clear_counts();
        reached = 1'b0;
        push_frame(1, 5, 1'b1, 20);
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge sys_clk);
            #1;
            if (data_rden_cnt[1] >= 2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("[TB] FAIL stall_start: got %0d pops expected 2", data_rden_cnt[1]);
        end
        @(posedge sys_clk);
        #1;
        bus.good_fifo_afull = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge sys_clk);
            #1;
            checks++;
            if (bus.port_data_rden !== '0) begin
                errors++;
                $display("[TB] FAIL stall_rden: cycle %0d got %b expected 0", s, bus.port_data_rden);
            end
            if (s > 0) begin
                checks++;
                if (bus.good_fifo_wren !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_wren: cycle %0d got 1 expected 0", s);
                end
            end
        end
        @(posedge sys_clk);
        #1;
        bus.good_fifo_afull = 1'b0;
        wait_drain("afull_stall");
        checks++;
        if (wren_cnt != 5 || data_rden_cnt[1] != 5 || info_rden_cnt[1] != 1) begin
            errors++;
            $display("[TB] FAIL stall_totals: got wren=%0d rden=%0d info=%0d expected 5,5,1",
                     wren_cnt, data_rden_cnt[1], info_rden_cnt[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit reached;
        clear_counts();
        reached = 1'b0;
        push_frame(3, 6, 1'b1, 30);
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge sys_clk);
            #1;
            if (data_rden_cnt[3] >= 3) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("[TB] FAIL midreset_start: got %0d pops expected 3", data_rden_cnt[3]);
        end
        rx_reset = 1'b1;
        #1;
        check_outputs_zero("midreset_async");
        @(posedge sys_clk);
        #1;
        check_outputs_zero("midreset_edge");
        exp_q.delete();
        exp_drop_q.delete();
        @(posedge sys_clk);
        @(negedge sys_clk);
        rx_reset = 1'b0;
        clear_counts();
        push_frame(0, 1, 1'b1, 31);
        push_frame(3, 1, 1'b1, 32);
        wait_drain("midreset_after");
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 3) begin
            errors++;
            $display("[TB] FAIL midreset_order: got %0d words first port %0d expected 2 words ports 0 then 3",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
    endtask

    task automatic test_single_word();
        clear_counts();
        push_frame(1, 1, 1'b1, 40);
        push_frame(1, 1, 1'b0, 41);
        wait_drain("single_word");
        checks++;
        if (wren_cnt != 1 || eof_cnt != 1) begin
            errors++;
            $display("[TB] FAIL single_wren: got wren=%0d eof=%0d expected 1 and 1", wren_cnt, eof_cnt);
        end
        checks++;
        if (drop_cnt != 1 || info_rden_cnt[1] != 2 || data_rden_cnt[1] != 2) begin
            errors++;
            $display("[TB] FAIL single_counts: got drop=%0d info=%0d rden=%0d expected 1,2,2",
                     drop_cnt, info_rden_cnt[1], data_rden_cnt[1]);
        end
    endtask

    initial begin
        rx_reset            = 1'b1;
        bus.good_fifo_afull = 1'b0;
        clear_counts();
        cyc = 0;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_back_to_back();
        test_afull_stall();
        test_reset_mid_frame();
        test_single_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
